pipeline_flow_ctrl: RTL and testbench



---
 rtl/pipeline_flow_ctrl_if.sv | 36 +++
 rtl/pipeline_flow_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_flow_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_flow_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the central flow controller.
// The datapath drives hazard/branch status (master); the controller returns PC-select and stage enables (slave).
interface pipeline_flow_ctrl_if;
    logic       ID_Branch_i;
    logic       ID_predict_i;
    logic [4:0] ID_Rs1_i;
    logic [4:0] ID_Rs2_i;
    logic       EX_MemRead_i;
    logic [4:0] EX_Rd_i;
    logic       EX_Branch_i;
    logic       Predict_wrong_i;
    logic       mem_busy_i;

    logic [1:0] pc_sel_o;
    logic       pc_write_o;
    logic       IFID_write_o;
    logic       IFID_flush_o;
    logic       IDEX_write_o;
    logic       IDEX_flush_o;
    logic       EXMEM_write_o;
    logic       pred_upd_o;

    modport slave (
        input  ID_Branch_i, ID_predict_i, ID_Rs1_i, ID_Rs2_i,
        input  EX_MemRead_i, EX_Rd_i, EX_Branch_i, Predict_wrong_i, mem_busy_i,
        output pc_sel_o, pc_write_o, IFID_write_o, IFID_flush_o,
        output IDEX_write_o, IDEX_flush_o, EXMEM_write_o, pred_upd_o
    );

    modport master (
        output ID_Branch_i, ID_predict_i, ID_Rs1_i, ID_Rs2_i,
        output EX_MemRead_i, EX_Rd_i, EX_Branch_i, Predict_wrong_i, mem_busy_i,
        input  pc_sel_o, pc_write_o, IFID_write_o, IFID_flush_o,
        input  IDEX_write_o, IDEX_flush_o, EXMEM_write_o, pred_upd_o
    );
endinterface

// File: rtl/pipeline_flow_ctrl.sv
// Central stall/flush/redirect sequencer for the 5-stage pipeline.
// Optional branch/mispredict statistics are built only when BRANCH_STATS_EN is defined.
module pipeline_flow_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipeline_flow_ctrl_if.slave ctrl,
    output logic [CNT_W-1:0]   branch_cnt_o,
    output logic [CNT_W-1:0]   mispredict_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_BUBBLE = 2'd1,
        ST_FREEZE    = 2'd2
    } st_t;

    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_PRED = 2'b01;
    localparam logic [1:0] PC_SEL_FIX  = 2'b10;

    st_t  st_q;
    st_t  st_d;

    logic       lu;
    logic       mp;
    logic [1:0] pc_sel;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_flush;
    logic       exmem_write;
    logic       pred_upd;

    assign lu = ctrl.EX_MemRead_i && (ctrl.EX_Rd_i != 5'd0) &&
                ((ctrl.EX_Rd_i == ctrl.ID_Rs1_i) || (ctrl.EX_Rd_i == ctrl.ID_Rs2_i));
    assign mp = ctrl.EX_Branch_i && ctrl.Predict_wrong_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            st_q <= ST_RUN;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d        = ST_RUN;
        pc_sel      = PC_SEL_SEQ;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        // One update per resolved branch: a frozen EX stage is not counted until it moves.
        pred_upd    = ctrl.EX_Branch_i && !ctrl.mem_busy_i;

        if (!rst_i) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            pred_upd    = 1'b0;
        end else if (ctrl.mem_busy_i) begin
            st_d        = ST_FREEZE;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (mp) begin
            // The ID instruction is squashed, so any load-use it raised is irrelevant.
            pc_sel      = PC_SEL_FIX;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (lu && (st_q != ST_LU_BUBBLE)) begin
            st_d        = ST_LU_BUBBLE;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_flush  = 1'b1;
        end else if (ctrl.ID_Branch_i && ctrl.ID_predict_i) begin
            pc_sel      = PC_SEL_PRED;
            ifid_flush  = 1'b1;
        end
    end

    assign ctrl.pc_sel_o      = pc_sel;
    assign ctrl.pc_write_o    = pc_write;
    assign ctrl.IFID_write_o  = ifid_write;
    assign ctrl.IFID_flush_o  = ifid_flush;
    assign ctrl.IDEX_write_o  = idex_write;
    assign ctrl.IDEX_flush_o  = idex_flush;
    assign ctrl.EXMEM_write_o = exmem_write;
    assign ctrl.pred_upd_o    = pred_upd;

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] cnt_inc;

    assign cnt_inc[0] = pred_upd;
    assign cnt_inc[1] = pred_upd && ctrl.Predict_wrong_i;

    // Index 0 counts resolved branches, index 1 counts mispredicts; both stick at all-ones.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    cnt_q <= '0;
                end else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    endgenerate

    assign branch_cnt_o     = g_cnt[0].cnt_q;
    assign mispredict_cnt_o = g_cnt[1].cnt_q;
`else
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Directed bench for pipeline_flow_ctrl: expected control vectors go through a scoreboard queue,
// statistics counters are checked against a saturating count kept by the bench.
module tb_pipeline_flow_ctrl;

    localparam int CNT_W = 4;

    // Vector order: pc_sel[1:0], pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_write, pred_upd
    localparam logic [8:0] E_RST   = 9'b00_0_0_0_0_0_0_0;
    localparam logic [8:0] E_FRZ   = 9'b00_0_0_0_0_0_0_0;
    localparam logic [8:0] E_NORM  = 9'b00_1_1_0_1_0_1_0;
    localparam logic [8:0] E_NORMU = 9'b00_1_1_0_1_0_1_1;
    localparam logic [8:0] E_LU    = 9'b00_0_0_0_1_1_1_0;
    localparam logic [8:0] E_PT    = 9'b01_1_1_1_1_0_1_0;
    localparam logic [8:0] E_MP    = 9'b10_1_1_1_1_1_1_1;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;

    logic clk_i;
    logic rst_i;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;

    pipeline_flow_ctrl_if bus();

    pipeline_flow_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ctrl             (bus.slave),
        .branch_cnt_o     (branch_cnt_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    sb_t sb_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  br_m     = 0;
    int  mp_m     = 0;

    task automatic drive(input logic idb, input logic idp, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic exmr, input logic [4:0] exrd, input logic exb, input logic pw,
                         input logic mb);
        bus.ID_Branch_i     = idb;
        bus.ID_predict_i    = idp;
        bus.ID_Rs1_i        = rs1;
        bus.ID_Rs2_i        = rs2;
        bus.EX_MemRead_i    = exmr;
        bus.EX_Rd_i         = exrd;
        bus.EX_Branch_i     = exb;
        bus.Predict_wrong_i = pw;
        bus.mem_busy_i      = mb;
    endtask

    task automatic sb_push(input string tag, input logic [8:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        sb_t e;
        logic [8:0] obs;
        e = sb_q.pop_front();
        obs = {bus.pc_sel_o, bus.pc_write_o, bus.IFID_write_o, bus.IFID_flush_o,
               bus.IDEX_write_o, bus.IDEX_flush_o, bus.EXMEM_write_o, bus.pred_upd_o};
        checks++;
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
        end
        $display("step %-12s ctrl=%b", e.tag, obs);
        if (e.exp[0] && rst_i) begin
            if (br_m < (1 << CNT_W) - 1) br_m++;
            if (bus.Predict_wrong_i && mp_m < (1 << CNT_W) - 1) mp_m++;
        end
    endtask

    // Inputs are already applied; compare mid-cycle, then advance to just after the next edge.
    task automatic step(input string tag, input logic [8:0] exp);
        sb_push(tag, exp);
        @(negedge clk_i);
        sb_check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        logic [CNT_W-1:0] eb;
        logic [CNT_W-1:0] em;
`ifdef BRANCH_STATS_EN
        eb = CNT_W'(br_m);
        em = CNT_W'(mp_m);
`else
        eb = '0;
        em = '0;
`endif
        checks++;
        assert (branch_cnt_o === eb) else begin
            failures++;
            $error("FAIL %s_br observed=%0d expected=%0d", tag, branch_cnt_o, eb);
        end
        checks++;
        assert (mispredict_cnt_o === em) else begin
            failures++;
            $error("FAIL %s_mp observed=%0d expected=%0d", tag, mispredict_cnt_o, em);
        end
        $display("cnt  %-12s branch=%0d mispredict=%0d", tag, branch_cnt_o, mispredict_cnt_o);
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1, 1, 5'd5, 5'd0, 1, 5'd5, 1, 1, 0);
        #2;
        sb_push("rst_hold", E_RST);
        sb_check();
        check_cnt("rst_hold");
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        @(posedge clk_i);
        #1;

        step("normal", E_NORM);

        // Load-use on rs1: one bubble, suppressed once, then re-evaluated.
        drive(0, 0, 5'd5, 5'd1, 1, 5'd5, 0, 0, 0);
        step("lu_rs1", E_LU);
        step("lu_supp", E_NORM);
        step("lu_again", E_LU);
        drive(0, 0, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0);
        step("lu_rs2_held", E_NORM);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("lu_clear", E_NORM);
        drive(0, 0, 5'd3, 5'd5, 1, 5'd5, 0, 0, 0);
        step("lu_rs2", E_LU);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("after_lu", E_NORM);
        drive(0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
        step("load_x0", E_NORM);
        drive(0, 0, 5'd1, 5'd2, 1, 5'd7, 0, 0, 0);
        step("load_nomatch", E_NORM);

        drive(1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        step("pred_taken", E_PT);
        drive(1, 0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
        step("pred_ntaken", E_NORM);

        drive(0, 0, 5'd5, 5'd0, 1, 5'd5, 1, 1, 0);
        step("mp_over_lu", E_MP);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("after_mp", E_NORM);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
        step("br_correct", E_NORMU);

        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1);
        for (int i = 0; i < 3; i++) step($sformatf("frz_mp%0d", i), E_FRZ);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0);
        step("frz_release", E_MP);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0);
        step("pw_no_branch", E_NORM);

        drive(0, 0, 5'd9, 5'd0, 1, 5'd9, 0, 0, 1);
        step("frz_lu", E_FRZ);
        drive(0, 0, 5'd9, 5'd0, 1, 5'd9, 0, 0, 0);
        step("frz_lu_rel", E_LU);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("idle", E_NORM);
        check_cnt("three_br");

        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
        step("br4", E_NORMU);
        step("br5", E_NORMU);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("idle", E_NORM);
        check_cnt("five_br");

        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, 0);
        for (int i = 6; i <= 17; i++) step($sformatf("br%0d", i), E_NORMU);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("idle", E_NORM);
        check_cnt("sat_br");

        // Reset in the middle of a freeze.
        drive(1, 1, 5'd0, 5'd0, 0, 5'd0, 1, 1, 1);
        step("frz_pre_rst", E_FRZ);
        rst_i = 1'b0;
        br_m = 0;
        mp_m = 0;
        #1;
        sb_push("rst_in_frz", E_RST);
        sb_check();
        check_cnt("rst_in_frz");
        #2;
        rst_i = 1'b1;
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, 0);
        step("post_rst_mp", E_MP);

        // Reset in the middle of a load-use bubble must clear the suppression.
        drive(0, 0, 5'd6, 5'd0, 1, 5'd6, 0, 0, 0);
        step("lu_pre_rst", E_LU);
        rst_i = 1'b0;
        br_m = 0;
        mp_m = 0;
        #1;
        sb_push("rst_in_lu", E_RST);
        sb_check();
        #2;
        rst_i = 1'b1;
        step("lu_post_rst", E_LU);
        drive(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        step("final", E_NORM);
        check_cnt("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
